// File: rtl/clk_div_pkg.sv
// clk_div_pkg -- shared definitions for the programmable clock divider.
//   Parameter defaults, the per-channel configuration struct and the
//   period/high-time clamp helpers.
//   Struct fields are sized to DIV_W_MAX / FRAC_W_MAX. Channels only populate
//   the low DIV_W / FRAC_W bits; the rest stay zero.
package clk_div_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int DIV_W_DEF    = 16;
  localparam int FRAC_W_DEF   = 8;
  localparam int DEF_DIV_DEF  = 10;
  localparam int DIV_W_MAX    = 32;
  localparam int FRAC_W_MAX   = 16;

  typedef logic [DIV_W_MAX-1:0]  div_t;
  typedef logic [FRAC_W_MAX-1:0] frac_t;
  // One bit wider than div_t so that div + carry cannot overflow.
  typedef logic [DIV_W_MAX:0]    per_t;

  typedef struct packed {
    div_t  div;
    div_t  high;
    frac_t frac;
  } chan_cfg_t;

  // Effective period: divisors below 2 run as 2, plus one cycle when the
  // fractional accumulator carried at the previous wrap.
  function automatic per_t period_of(input div_t div, input logic carry);
    per_t d;
    d = (div < div_t'(2)) ? per_t'(2) : per_t'(div);
    return d + per_t'(carry);
  endfunction

  // High time is clamped against the effective period so that at least one
  // low cycle remains.
  function automatic per_t high_of(input div_t high, input per_t p);
    return (per_t'(high) >= p) ? p - per_t'(1) : per_t'(high);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan -- one divider channel.
//   clk_in, rst_n   : clock, async active-low reset (already synchronised)
//   en              : run enable; low holds cnt=0 and both outputs low
//   sync            : realign pulse; this cycle counts as cnt=0
//   wr              : shadow write strobe for this channel
//   ld_div/high/frac: values to write into the shadow
//   clk_out, tick   : registered divided clock and period-start strobe
//   pending         : shadow written but not yet applied
// Macro CLK_DIV_FRAC_EN adds the fractional accumulator.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              wr,
  input  logic [DIV_W-1:0]  ld_div,
  input  logic [DIV_W-1:0]  ld_high,
  input  logic [FRAC_W-1:0] ld_frac,
  output logic              clk_out,
  output logic              tick,
  output logic              pending
);

  localparam int XW = DIV_W_MAX + 1;
  localparam chan_cfg_t CFG_RST = '{div: div_t'(DEF_DIV), high: div_t'(DEF_DIV / 2), frac: '0};

  chan_cfg_t          act, shadow, wr_cfg, sh_nxt, cfg_use;
  logic [DIV_W-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]      cnt_x, cnt_use;
  per_t               p, h;
  logic               upd, wrap, carry_use;

  always_comb begin
    wr_cfg      = '0;
    wr_cfg.div  = div_t'(ld_div);
    wr_cfg.high = div_t'(ld_high);
`ifdef CLK_DIV_FRAC_EN
    wr_cfg.frac = frac_t'(ld_frac);
`endif
  end

  // A write in the same cycle as a transfer point is applied directly.
  assign sh_nxt  = wr ? wr_cfg : shadow;
  assign upd     = wr | pending;
  // During sync the new period starts in this very cycle, so it already
  // uses the incoming configuration.
  assign cfg_use = (sync && upd) ? sh_nxt : act;

  assign p       = period_of(cfg_use.div, carry_use);
  assign h       = high_of(cfg_use.high, p);
  assign cnt_x   = XW'(cnt);
  assign cnt_use = sync ? '0 : cnt_x;
  assign wrap    = en && !sync && (cnt_x == p - XW'(1));
  assign cnt_nxt = wrap ? '0 : DIV_W'(cnt_use + XW'(1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      act     <= CFG_RST;
      shadow  <= CFG_RST;
    end else begin
      if (wr) shadow <= wr_cfg;
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        clk_out <= (cnt_use < h);
        tick    <= (cnt_use == '0);
      end
      if ((wrap || sync || !en) && upd) begin
        act     <= sh_nxt;
        pending <= 1'b0;
      end else if (wr) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic              carry_q;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum   = {1'b0, acc} + {1'b0, act.frac[FRAC_W-1:0]};
  assign carry_use = carry_q & ~sync;

  // Carry out of the accumulator stretches the following period by one.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (sync) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (wrap) begin
      acc     <= acc_sum[FRAC_W-1:0];
      carry_q <= acc_sum[FRAC_W];
    end
  end

  logic unused_frac;
  assign unused_frac = ^act.frac;
`else
  assign carry_use = 1'b0;

  logic unused_frac;
  assign unused_frac = ^{ld_frac, act.frac};
`endif

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog -- multi-channel programmable clock divider.
//   clk_in   : sole clock
//   reset_n  : async active-low reset, release synchronised internally
//   en       : per-channel run enable
//   sync     : realign all channels, apply pending shadows
//   ld, ld_ch, ld_div, ld_high, ld_frac : shadow write port
//   clk_out, tick, pending : per-channel outputs
// Optional macro CLK_DIV_FRAC_EN enables fractional division.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int DEF_DIV  = DEF_DIV_DEF
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                ld,
  input  logic [3:0]          ld_ch,
  input  logic [DIV_W-1:0]    ld_div,
  input  logic [DIV_W-1:0]    ld_high,
  input  logic [FRAC_W-1:0]   ld_frac,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  // Assert immediately, release after two clk_in edges.
  logic [1:0] rst_ff;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) rst_ff <= '0;
    else          rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  // ld_ch values at or above CHANNELS match no channel and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = ld && (ld_ch == 4'(i));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .FRAC_W  (FRAC_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr),
      .ld_div  (ld_div),
      .ld_high (ld_high),
      .ld_frac (ld_frac),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;
  localparam int CH = 4, DW = 16, FW = 8;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic [CH-1:0] en;
  logic          sync, ld;
  logic [3:0]    ld_ch;
  logic [DW-1:0] ld_div, ld_high;
  logic [FW-1:0] ld_frac;
  logic [CH-1:0] clk_out, tick, pending;

  int n_checks = 0, n_fail = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(.CHANNELS(CH), .DIV_W(DW), .FRAC_W(FW), .DEF_DIV(10)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .sync(sync), .ld(ld),
    .ld_ch(ld_ch), .ld_div(ld_div), .ld_high(ld_high), .ld_frac(ld_frac),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for tick", tag);
  endtask

  task automatic wait_tick(input int ch);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (tick[ch]) return;
    end
    timeout("wait_tick");
  endtask

  // Called at a negedge where tick[ch] is high; returns at the next tick.
  task automatic measure(input int ch, output int per, output int hi);
    per = 1;
    hi  = int'(clk_out[ch]);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (tick[ch]) return;
      per++;
      hi += int'(clk_out[ch]);
    end
    timeout("measure");
  endtask

  // Two ticks guarantee the next period uses any freshly written config.
  task automatic settle(input int ch);
    wait_tick(ch);
    wait_tick(ch);
  endtask

  task automatic ld_cfg(input int ch, input int dv, input int hg, input int fr);
    ld = 1'b1; ld_ch = 4'(ch); ld_div = DW'(dv); ld_high = DW'(hg); ld_frac = FW'(fr);
    @(negedge clk_in);
    ld = 1'b0;
  endtask

  initial begin
    int per, hi, nhi;
    reset_n = 1'b0; en = '1; sync = 1'b0; ld = 1'b0; ld_ch = '0;
    ld_div = '0; ld_high = '0; ld_frac = '0;

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pending", pending, 0);
    reset_n = 1'b1;

    // Default period 10, 5 high, all channels
    for (int c = 0; c < CH; c++) begin
      wait_tick(c);
      measure(c, per, hi);
      chk($sformatf("def_per%0d", c), per, 10);
      chk($sformatf("def_hi%0d", c), hi, 5);
    end

    // Mid-period write on ch1: old period completes, then 7/3
    wait_tick(1);
    per = 1; hi = int'(clk_out[1]);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (tick[1]) break;
      per++;
      hi += int'(clk_out[1]);
      if (per == 3) begin ld = 1'b1; ld_ch = 4'd1; ld_div = 16'd7; ld_high = 16'd3; end
      if (per == 4) begin ld = 1'b0; chk("pend_set", pending[1], 1); end
    end
    chk("old_per", per, 10);
    chk("old_hi", hi, 5);
    chk("pend_clr", pending[1], 0);
    measure(1, per, hi);
    chk("new_per", per, 7);
    chk("new_hi", hi, 3);

    // div=1 runs as 2; high=0 keeps clk_out low but ticks continue
    ld_cfg(2, 1, 1, 0);
    settle(2);
    measure(2, per, hi);
    chk("div1_per", per, 2);
    chk("div1_hi", hi, 1);
    ld_cfg(2, 4, 0, 0);
    settle(2);
    measure(2, per, hi);
    chk("h0_per", per, 4);
    chk("h0_hi", hi, 0);

    // Sync realign with a same-cycle write to ch2
    ld_cfg(0, 3, 1, 0);
    ld_cfg(1, 5, 2, 0);
    repeat (3) @(negedge clk_in);
    sync = 1'b1; ld = 1'b1; ld_ch = 4'd2; ld_div = 16'd8; ld_high = 16'd4;
    @(negedge clk_in);
    sync = 1'b0; ld = 1'b0;
    chk("sync_tick", tick, 4'b1111);
    chk("sync_clk", clk_out, 4'b1111);
    chk("sync_pend", pending, 0);
    measure(0, per, hi);
    chk("sync_per0", per, 3);
    chk("sync_hi0", hi, 1);
    wait_tick(2);
    measure(2, per, hi);
    chk("sync_per2", per, 8);
    chk("sync_hi2", hi, 4);

    // Out-of-range channel write is ignored
    ld = 1'b1; ld_ch = 4'd9; ld_div = 16'd3; ld_high = 16'd1;
    @(negedge clk_in);
    ld = 1'b0;
    chk("badch_pend", pending, 0);
    settle(3);
    measure(3, per, hi);
    chk("badch_per", per, 10);

    // en low holds outputs; first high cycle one cycle after en rises
    en[3] = 1'b0;
    @(negedge clk_in);
    nhi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      nhi += int'(clk_out[3]) + int'(tick[3]);
    end
    chk("en_off", nhi, 0);
    en[3] = 1'b1;
    @(negedge clk_in);
    chk("en_clk", clk_out[3], 1);
    chk("en_tick", tick[3], 1);

    // Async reset mid-high phase, defaults afterwards
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (clk_out[0]) break;
    end
    chk("pre_rst_hi", clk_out[0], 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_pend", pending, 0);
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    wait_tick(0);
    measure(0, per, hi);
    chk("post_rst_per", per, 10);
    chk("post_rst_hi", hi, 5);
    wait_tick(1);
    measure(1, per, hi);
    chk("post_rst_per1", per, 10);

`ifdef CLK_DIV_FRAC_EN
    begin
      int sum, p0, p1;
      sync = 1'b1; ld = 1'b1; ld_ch = 4'd0; ld_div = 16'd4; ld_high = 16'd2; ld_frac = 8'h80;
      @(negedge clk_in);
      sync = 1'b0; ld = 1'b0;
      measure(0, per, hi);
      sum = 0; p0 = 0; p1 = 0;
      for (int k = 0; k < 256; k++) begin
        measure(0, per, hi);
        if (k == 0) p0 = per;
        if (k == 1) p1 = per;
        sum += per;
      end
      chk("frac_p0", p0, 4);
      chk("frac_p1", p1, 5);
      chk("frac_sum", sum, 1152);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
